// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared constants and types for the Kyber (q = 3329) arithmetic blocks.
//   Q          : Kyber modulus
//   QINV       : q^-1 mod 2^16 as a signed 16-bit value (62209 unsigned)
//   BARRETT_V  : Barrett constant round(2^26 / q)
//   coeff_t    : signed 16-bit polynomial coefficient
// -----------------------------------------------------------------------------
package kyber_pkg;

   localparam int Q         = 3329;
   localparam int QINV      = -3327;
   localparam int BARRETT_V = 20159;

   typedef logic signed [15:0] coeff_t;

endpackage

// File: rtl/montgomery_reduce.sv
// -----------------------------------------------------------------------------
// montgomery_reduce
// Combinational Montgomery reduction: r = a * 2^-16 mod q, with r in (-q, q)
// whenever |a| < q * 2^15.
// Ports:
//   a : 32-bit signed input (typically a coefficient x twiddle product)
//   r : 16-bit signed reduced result
// -----------------------------------------------------------------------------
module montgomery_reduce
   import kyber_pkg::*;
(
   input  logic signed [31:0] a,
   output coeff_t             r
);

   localparam logic signed [47:0] QINV_W = 48'(QINV);
   localparam logic signed [47:0] Q_W    = 48'(Q);

   logic signed [47:0] a_ext;
   logic signed [47:0] a_qinv;
   logic signed [15:0] m;
   logic signed [47:0] m_ext;
   logic signed [47:0] mq;
   logic signed [47:0] t;
   logic               unused_bits;

   assign a_ext  = 48'(a);
   assign a_qinv = a_ext * QINV_W;

   // m is chosen so that a - m*q is divisible by 2^16; only the low
   // 16 bits of a*QINV matter and they are reinterpreted as signed.
   assign m      = a_qinv[15:0];
   assign m_ext  = 48'(m);
   assign mq     = m_ext * Q_W;
   assign t      = a_ext - mq;

   // Low 16 bits of t are zero by construction, so the arithmetic shift
   // by 16 is just a slice of bits [31:16].
   assign r      = t[31:16];

   assign unused_bits = ^{a_qinv[47:16], t[47:32], t[15:0]};

endmodule

// File: rtl/ntt_butterfly.sv
// -----------------------------------------------------------------------------
// ntt_butterfly
// Two-stage pipelined Kyber NTT butterfly.
//   inv = 0 (Cooley-Tukey):     t = fqmul(v, zeta); upper = u + t; lower = u - t
//   inv = 1 (Gentleman-Sande):  upper = barrett(u + v); lower = fqmul(v - u, zeta)
// One operand set accepted per clock, results appear 2 clocks later, no
// backpressure. Outputs hold their last value while out_valid is low.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand set present this cycle
//   inv        butterfly mode, sampled with in_valid
//   u, v       signed coefficients (upper / lower input)
//   zeta       signed twiddle in Montgomery domain
//   out_valid  results valid
//   out_upper  signed upper result
//   out_lower  signed lower result
// -----------------------------------------------------------------------------
module ntt_butterfly
   import kyber_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   input  logic   inv,
   input  coeff_t u,
   input  coeff_t v,
   input  coeff_t zeta,
   output logic   out_valid,
   output coeff_t out_upper,
   output coeff_t out_lower
);

   // ---------------- stage 1: pre-add (GS) and multiply ----------------
   coeff_t             gs_sum;
   coeff_t             gs_diff;
   coeff_t             mul_op;
   coeff_t             pass_op;
   logic signed [31:0] prod;

   // GS sum/difference deliberately wrap at 16 bits before use.
   assign gs_sum  = u + v;
   assign gs_diff = v - u;
   assign mul_op  = inv ? gs_diff : v;
   assign pass_op = inv ? gs_sum  : u;
   assign prod    = 32'(mul_op) * 32'(zeta);

   logic               s1_valid;
   logic               s1_inv;
   logic signed [31:0] s1_p;
   coeff_t             s1_a;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_inv   <= 1'b0;
         s1_p     <= '0;
         s1_a     <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_inv <= inv;
            s1_p   <= prod;
            s1_a   <= pass_op;
         end
      end
   end

   // ---------------- stage 2: reductions and final add/sub --------------
   coeff_t r;

   montgomery_reduce u_mont (
      .a (s1_p),
      .r (r)
   );

   // Barrett: a - q * ((V*a + 2^25) >>> 26). |V*a| < 2^31 for any 16-bit a.
   logic signed [31:0] b_prod;
   logic signed [31:0] b_quot;
   logic signed [31:0] b_full;
   coeff_t             barrett_res;
   logic               unused_barrett_hi;

   assign b_prod      = 32'(BARRETT_V) * 32'(s1_a) + 32'(1 << 25);
   assign b_quot      = b_prod >>> 26;
   assign b_full      = 32'(s1_a) - b_quot * 32'(Q);
   assign barrett_res = b_full[15:0];
   assign unused_barrett_hi = ^b_full[31:16];

   coeff_t upper_next;
   coeff_t lower_next;

   always_comb begin
      upper_next = s1_a + r;
      lower_next = s1_a - r;
      if (s1_inv) begin
         upper_next = barrett_res;
         lower_next = r;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_upper <= '0;
         out_lower <= '0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_upper <= upper_next;
            out_lower <= lower_next;
         end
      end
   end

endmodule

// File: tb/tb_ntt_butterfly.sv
// -----------------------------------------------------------------------------
// tb_ntt_butterfly
// Directed bench for ntt_butterfly: hand-computed vectors, 16-bit extremes,
// an 8-deep alternating-mode stream and a mid-clock asynchronous reset.
// -----------------------------------------------------------------------------
module tb_ntt_butterfly;
   import kyber_pkg::*;

   logic   clk      = 1'b0;
   logic   rst      = 1'b0;
   logic   in_valid = 1'b0;
   logic   inv      = 1'b0;
   coeff_t u        = '0;
   coeff_t v        = '0;
   coeff_t zeta     = '0;
   logic   out_valid;
   coeff_t out_upper;
   coeff_t out_lower;

   ntt_butterfly dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inv       (inv),
      .u         (u),
      .v         (v),
      .zeta      (zeta),
      .out_valid (out_valid),
      .out_upper (out_upper),
      .out_lower (out_lower)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int vcount   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int up;
      int lo;
      int cyc;
      bit inv;
   } exp_t;

   exp_t expq[$];

   task automatic check(input string tag, input longint obs, input longint expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint wrap16(input longint x);
      longint y;
      y = x & 64'hFFFF;
      if (y >= 32768) y = y - 65536;
      return y;
   endfunction

   // r such that r * 2^16 == p - m*q exactly, m = signed low16(p * q^-1).
   function automatic longint mont(input longint p);
      longint m;
      m = wrap16(p * -3327);
      return wrap16((p - m * 3329) / 65536);
   endfunction

   function automatic longint barrett(input longint a);
      longint t;
      t = (20159 * a + (64'sd1 <<< 25)) >>> 26;
      return a - 3329 * t;
   endfunction

   task automatic model(input bit i, input int uu, input int vv, input int zz,
                        output int eu, output int el);
      longint r;
      if (!i) begin
         r  = mont(longint'(vv) * zz);
         eu = int'(wrap16(uu + r));
         el = int'(wrap16(uu - r));
      end else begin
         r  = mont(wrap16(vv - uu) * zz);
         eu = int'(barrett(wrap16(uu + vv)));
         el = int'(r);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic issue(input bit i, input int uu, input int vv, input int zz,
                        input int eu, input int el);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      inv      = i;
      u        = 16'(uu);
      v        = 16'(vv);
      zeta     = 16'(zz);
      e.up  = eu;
      e.lo  = el;
      e.cyc = cyc;
      e.inv = i;
      expq.push_back(e);
      $display("issue  inv=%0d u=%0d v=%0d zeta=%0d -> expect upper=%0d lower=%0d",
               i, uu, vv, zz, eu, el);
   endtask

   task automatic issue_m(input bit i, input int uu, input int vv, input int zz);
      int eu;
      int el;
      model(i, uu, vv, zz, eu, el);
      issue(i, uu, vv, zz, eu, el);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 20 && expq.size() != 0; k++) @(posedge clk);
      check(tag, expq.size(), 0);
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid) begin
         vcount++;
         if (expq.size() == 0) begin
            check("spurious_valid", out_valid, 0);
         end else begin
            e = expq.pop_front();
            $display("result upper=%0d lower=%0d (expect %0d %0d) cyc=%0d",
                     out_upper, out_lower, e.up, e.lo, cyc);
            check("upper", out_upper, e.up);
            check("lower", out_lower, e.lo);
            check("latency", cyc - e.cyc, 2);
            if (e.inv)
               check("gs_r_in_range", (out_lower > -3329 && out_lower < 3329) ? 1 : 0, 1);
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_upper", out_upper, 0);
      check("rst_out_lower", out_lower, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // CT, zeta = 0: single pulse, upper = lower = u
      vcount = 0;
      issue(1'b0, 100, 200, 0, 100, 100);
      idle(1);
      drain("drain_ct_zeta0");
      idle(3);
      check("ct_zeta0_pulse_width", vcount, 1);

      // CT, r = -779
      issue(1'b0, 500, 100, 10, -279, 1279);
      idle(1);
      drain("drain_ct_basic");

      // GS vectors back to back; last one left on the outputs for hold check
      issue(1'b1, 100, 200, 0, 300, 0);
      issue(1'b1, 500, 600, 10, 1100, -779);
      issue(1'b1, 3000, 3000, 0, -658, 0);
      idle(1);
      drain("drain_gs");
      idle(3);
      @(negedge clk);
      check("hold_out_valid", out_valid, 0);
      check("hold_upper", out_upper, -658);
      check("hold_lower", out_lower, 0);

      // 16-bit extremes in CT
      issue_m(1'b0, 32767, 32767, 1664);
      issue_m(1'b0, -32768, -32768, -1664);
      issue_m(1'b0, 32767, -32768, 1664);
      issue_m(1'b0, -32768, 32767, -1664);
      issue_m(1'b0, 32767, 32767, -1664);
      issue_m(1'b0, -32768, -32768, 1664);
      idle(1);
      drain("drain_extremes");

      // 8-deep stream, alternating CT/GS with random operands
      vcount = 0;
      for (int k = 0; k < 8; k++) begin
         issue_m(k[0],
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 3328)) - 1664);
      end
      idle(1);
      drain("drain_stream");
      check("stream_valid_count", vcount, 8);

      // asynchronous reset mid-clock with two operations in flight
      issue_m(1'b0, 123, 456, 789);
      issue_m(1'b1, -1000, 2000, -1500);
      @(posedge clk);
      #1 in_valid = 1'b0;
      #2 rst = 1'b1;
      expq.delete();
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_out_upper", out_upper, 0);
      check("async_rst_out_lower", out_lower, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      vcount = 0;
      idle(6);
      check("post_reset_quiet", vcount, 0);

      // pipeline still works after reset
      issue(1'b0, 500, 100, 10, -279, 1279);
      idle(1);
      drain("drain_post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ntt_butterfly.md
Name: ntt_butterfly

Overview:
- Single Kyber (q = 3329) NTT butterfly datapath stage.
- Default mode is Cooley-Tukey (forward NTT): t = fqmul(v, zeta), upper = u + t, lower = u − t.
- Optional mode is Gentleman-Sande (inverse NTT): upper = barrett(u + v), lower = fqmul(v − u, zeta).
- Fully pipelined; accepts one operand set per clock. Instantiated by the NTT core's butterfly array.

Parameters:
- Q, 3329, Kyber modulus.
- QINV, -3327, q⁻¹ mod 2^16 as a signed 16-bit value (62209 unsigned).
- BARRETT_V, 20159, Barrett constant ((2^26 + q/2) / q).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set present this cycle
- inv  in  1  0 = Cooley-Tukey, 1 = Gentleman-Sande; sampled with in_valid
- u  in  16  signed coefficient, upper input
- v  in  16  signed coefficient, lower input
- zeta  in  16  signed twiddle in Montgomery domain
- out_valid  out  1  results valid
- out_upper  out  16  signed upper result
- out_lower  out  16  signed lower result

Behaviour:
- Reset, asynchronous: out_valid, out_upper, out_lower and all pipeline registers go to 0. In-flight operations are discarded. No output pulse follows reset release until new in_valid.
- Latency is exactly 2 clocks from in_valid sampled high to out_valid high. Throughput is 1 per clock. There is no backpressure.
- Stage 1 registers:
  - CT: the 32-bit signed product p = v·zeta, plus u.
  - GS: s = u + v and d = v − u, both 16-bit wrap; then p = d·zeta, plus s.
  - Also registers valid and inv.
- Stage 2: Montgomery reduce of p:
  - m = low 16 bits of (p·QINV), taken as signed.
  - r = (p − m·Q) >>> 16, arithmetic shift. The low 16 bits are exactly zero.
  - r is in (−Q, Q) for |p| < Q·2^15.
- CT outputs: out_upper = u + r, out_lower = u − r. Both are 16-bit two's-complement wraparound with no further reduction.
- GS outputs: out_upper = barrett(s), out_lower = r.
  - barrett(a) = a − Q·((BARRETT_V·a + 2^25) >>> 26).
  - Result is in [−(Q−1)/2, (Q−1)/2].
- out_upper and out_lower hold their values when out_valid is low. Registers update only when the corresponding valid is high.
- All multiplies are signed. Intermediates are sized to avoid overflow: 32-bit p, 48-bit m·Q/p·QINV, 32-bit Barrett product.
- zeta = 0 gives r = 0, so CT yields upper = lower = u.
- Back-to-back in_valid with alternating inv must produce independent, correctly ordered results.

Decomposition:
- Shared package kyber_pkg: Q, QINV, BARRETT_V, coeff_t (signed 16-bit) typedef.
- One sub-module, montgomery_reduce: 32-bit signed in, 16-bit signed out, combinational.
- Barrett reduction stays inline.

Test Plan:
- CT, u=100, v=200, zeta=0 → after 2 clocks: out_upper=100, out_lower=100, out_valid pulse of 1 cycle.
- CT, u=500, v=100, zeta=10 → r = −779: out_upper = −279, out_lower = 1279.
- GS, u=100, v=200, zeta=0 → out_upper = 300, out_lower = 0. GS, u=3000, v=3000, zeta=0 → out_upper = barrett(6000) = −658.
- Streaming: 8 consecutive in_valid cycles of random CT/GS operands, compared against a software model.
  - out_valid must be high 8 consecutive cycles with results in issue order.
- Reset asserted asynchronously (mid-clock) with 2 operations in flight → outputs and out_valid clear immediately. Nothing emerges afterwards without new input.
- Extremes: u = v = 32767 and −32768, zeta = ±1664, CT → results match 16-bit wrap model. Montgomery r is always in (−3329, 3329).
